// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle RV32I sequencer.
// Owns the PC and the instruction fetch. Each instruction walks through
// FETCH, DECODE, EXECUTE, optional MEM and WRITE_BACK. Both memory ports use a
// req/ack handshake that tolerates any number of wait states. Illegal
// instructions, non-word loads/stores and misaligned data or jump targets
// park the core in HALT with a sticky trap until the next reset.
module cpu_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     insn,
  input  logic            invalid,
  output logic            rf_rden,
  output logic            rf_wren,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] alu_out,
  input  logic            br_taken,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            trap
);

  // Major opcodes, insn[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // Only word accesses are supported
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITE_BACK,
    HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  // Working registers
  logic [XLEN-1:0] x_val;
  logic            taken;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_data;

  // Load enables produced by the sequencer
  logic insn_ld;
  logic exec_ld;
  logic load_ld;
  logic pc_ld;

  // Instruction field decode
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       is_branch;
  logic       is_jal;
  logic       is_jalr;
  logic       writes_rd;
  logic       bad_mem_width;

  // Next-PC path
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_nxt;
  logic            target_misaligned;
  logic            data_misaligned;

  // B-type immediate, sign-extended to XLEN
  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] i);
    logic signed [12:0] imm;
    imm = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    return {{(XLEN-13){imm[12]}}, imm};
  endfunction

  // J-type immediate, sign-extended to XLEN
  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] i);
    logic signed [20:0] imm;
    imm = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    return {{(XLEN-21){imm[20]}}, imm};
  endfunction

  assign opcode    = insn[6:2];
  assign funct3    = insn[14:12];
  assign rd        = insn[11:7];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_mem    = is_load || is_store;
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);

  assign bad_mem_width = is_mem && (funct3 != F3_WORD);

  // Register-writing classes; x0 is never written
  assign writes_rd = (rd != 5'd0) &&
                     ((opcode == OPC_OP)    || (opcode == OPC_OPIMM) ||
                      (opcode == OPC_LUI)   || (opcode == OPC_AUIPC) ||
                      is_load || is_jal || is_jalr);

  assign data_misaligned   = (x_val[1:0] != 2'b00);
  assign target_misaligned = (pc_nxt[1:0] != 2'b00);

  assign imem_addr  = pc;
  assign dmem_addr  = x_val;
  assign dmem_wdata = store_data;

  // Next-PC selection; all additions wrap modulo 2^XLEN
  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    pc_nxt   = pc_plus4;
    if (is_jal) begin
      pc_nxt = pc + imm_j(insn);
    end else if (is_jalr) begin
      pc_nxt = x_val & ~XLEN'(1);
    end else if (is_branch && taken) begin
      pc_nxt = pc + imm_b(insn);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequencer next-state, handshakes and per-state strobes
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    rf_rden   = 1'b0;
    rf_wren   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    trap      = 1'b0;
    wb_data   = '0;
    insn_ld   = 1'b0;
    exec_ld   = 1'b0;
    load_ld   = 1'b0;
    pc_ld     = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          insn_ld   = 1'b1;
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        rf_rden = 1'b1;
        if (invalid || bad_mem_width) begin
          state_nxt = HALT;
        end else begin
          state_nxt = EXECUTE;
        end
      end

      EXECUTE: begin
        exec_ld   = 1'b1;
        state_nxt = is_mem ? MEM : WRITE_BACK;
      end

      MEM: begin
        // A misaligned address never reaches the data bus
        if (data_misaligned) begin
          state_nxt = HALT;
        end else begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ack) begin
            load_ld   = 1'b1;
            state_nxt = WRITE_BACK;
          end
        end
      end

      WRITE_BACK: begin
        // A misaligned target faults without retiring or writing rd
        if (target_misaligned) begin
          state_nxt = HALT;
        end else begin
          retire  = 1'b1;
          pc_ld   = 1'b1;
          rf_wren = writes_rd;
          if (is_load) begin
            wb_data = load_data;
          end else if (is_jal || is_jalr) begin
            wb_data = pc_plus4;
          end else begin
            wb_data = x_val;
          end
          state_nxt = FETCH;
        end
      end

      HALT: begin
        trap = 1'b1;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Architectural state visible after reset: PC, latched instruction, result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC;
      insn  <= '0;
      x_val <= '0;
    end else begin
      if (insn_ld) begin
        insn <= imem_rdata;
      end
      if (exec_ld) begin
        x_val <= alu_out;
      end
      if (pc_ld) begin
        pc <= pc_nxt;
      end
    end
  end

  // Operand captures that are always written before being used
  always_ff @(posedge clk) begin
    if (exec_ld) begin
      taken      <= br_taken;
      store_data <= rs2_val;
    end
    if (load_ld) begin
      load_data <= dmem_rdata;
    end
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Parametrised multi-cycle sequencer for the RV32I core. It supersedes the fixed five-state controller and owns the PC and the instruction fetch. It sequences the decoder, regfile and ALU through FETCH/DECODE/EXECUTE/MEM/WRITE_BACK, handshaking with instruction and data memories that may insert wait states. It handles branches, jumps, word loads and stores, and traps on illegal or misaligned instructions.

## Interface
- XLEN, 32: datapath and address width (≥ 32).
- RESET_PC, 0: PC value after reset; must be 4-aligned.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_req  out  1  instruction fetch request; held until acked.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- insn  out  32  latched instruction, to decoder.
- invalid  in  1  decoder illegal-instruction flag.
- rf_rden  out  1  regfile read enable.
- rf_wren  out  1  regfile write enable, one-cycle pulse.
- rs2_val  in  XLEN  regfile operand 2 (store data).
- alu_out  in  XLEN  ALU result (address/sum/compare).
- br_taken  in  1  ALU branch-condition result.
- dmem_req  out  1  data request; held until acked.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_addr  out  XLEN  data address (= x_val).
- dmem_wdata  out  XLEN  store data.
- dmem_ack  in  1  data access complete; load data valid.
- dmem_rdata  in  XLEN  load data.
- wb_data  out  XLEN  regfile write data.
- pc  out  XLEN  current PC.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  sticky; core halted.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITE_BACK, HALT.
- IDLE: entered only from reset. Goes to FETCH on the next cycle.
- FETCH: imem_req=1 with imem_addr=pc. On the first cycle with imem_ack=1, latch insn<=imem_rdata, drop imem_req and go to DECODE.
- DECODE: rf_rden=1.
  - If invalid=1, or insn[6:2] is LOAD/STORE with funct3≠010, go to HALT.
  - Otherwise go to EXECUTE.
- EXECUTE: latch x_val<=alu_out and taken<=br_taken.
  - LOAD (00000) and STORE (01000) go to MEM.
  - All other instructions go to WRITE_BACK.
- MEM: dmem_req=1, dmem_we=(STORE), dmem_addr=x_val, dmem_wdata=rs2_val latched at EXECUTE.
  - If x_val[1:0]≠0, go to HALT without asserting dmem_req.
  - On dmem_ack, latch load data and go to WRITE_BACK.
- WRITE_BACK: update pc, pulse retire, then go to FETCH.
  - rf_wren pulses for OP, OP-IMM, LUI, AUIPC, LOAD, JAL and JALR, but only when insn[11:7]≠0.
  - wb_data: LOAD gives the load data; JAL/JALR give pc+4; all others give x_val.
- Next PC:
  - BRANCH (11000) with taken: pc+imm_B.
  - JAL (11011): pc+imm_J.
  - JALR (11001): x_val & ~1.
  - Otherwise: pc+4.
  - imm_B and imm_J are decoded and sign-extended internally to XLEN. Additions wrap modulo 2^XLEN.
- Misaligned target (next-pc[1:0]≠0) goes to HALT: no retire, and pc keeps the faulting instruction address. rf_wren is suppressed for that instruction.
- HALT: trap=1. All requests and enables are 0. Only reset exits HALT.

## Timing
- Reset (rst=0) is asynchronous. Values while reset is asserted:
  - state=IDLE, pc=RESET_PC, insn=0, x_val=0, wb_data=0.
  - imem_req, dmem_req, dmem_we, rf_rden, rf_wren, retire and trap are all 0.
- Reset mid-request drops imem_req/dmem_req immediately. Any ack arriving during or after reset, before the next request, is ignored.
- imem_ack or dmem_ack may arrive in the same cycle the request rises (zero wait). Each wait cycle adds one cycle.
- Zero-wait latency, from FETCH entry to the cycle after the retire pulse:
  - ALU, branch and jump instructions: 4 cycles.
  - Load and store: 5 cycles.
- First FETCH occurs 1 cycle after rst deasserts.
- Acks outside FETCH/MEM are ignored. A request, once raised, stays high with a stable address until acked.
- retire and rf_wren assert in the same cycle. pc shows the new value on the following cycle.

## Test plan
- add x0-x3 sequence (0x00208033-style, rd=1), zero-wait memories → retire every 4 cycles; rf_wren with wb_data=alu_out; pc 0,4,8.
- LW with dmem_ack delayed 3 cycles → dmem_req high 4 cycles with stable dmem_addr; wb_data=dmem_rdata=0xDEADBEEF; 8 cycles total.
- BEQ taken with imm=-8 at pc=0x10 → next imem_addr=0x08. Not taken → 0x14. rf_wren stays 0 in both cases.
- JAL rd=1 imm=0x100 at pc=0x20 → wb_data=0x24, pc=0x120. JALR with alu_out=0x203 → trap=1, pc stays at the JALR address.
- invalid=1 in DECODE, or SW with x_val=0x102 → HALT, trap=1, no dmem_req, no retire; stays halted until reset.
- rst asserted while imem_req=1 and waiting → outputs go to reset values within the same cycle; after release, FETCH at RESET_PC.
